// File: rtl/pic_inta_sequencer.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse 8086 acknowledge,
// owns the in-service register, handles EOI/AEOI and rotating priority.
module pic_inta_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       pri_valid,
    input  logic [2:0] pri_level,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       rotate_on_eoi,
    input  logic       eoi_req,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] irr_clear,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [2:0] prio_base
);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t     state, state_nxt;
    logic       inta_q, fall, rise;
    logic [2:0] lvl, lvl_nxt;
    logic       spurious, spurious_nxt;
    logic       int_out_nxt, data_oe_nxt;
    logic [7:0] isr_nxt, irr_clear_nxt, data_out_nxt;
    logic [2:0] prio_base_nxt;

    logic       isr_any, qualify, ack_valid, eoi_hit;
    logic [2:0] min_rank, min_lvl, req_rank, cand_rank, cand_lvl, eoi_tgt;
    logic [7:0] set_mask, eoi_mask, aeoi_mask;

    assign fall      = inta_q & ~inta_n;
    assign rise      = ~inta_q & inta_n;
    assign ack_valid = pri_valid & irr[pri_level] & ~imr[pri_level];
    assign req_rank  = pri_level - prio_base;

    // Scan ranks from lowest priority upward so the last hit is the highest-priority ISR bit.
    always_comb begin
        isr_any   = |isr;
        min_rank  = '1;
        min_lvl   = '0;
        cand_rank = '0;
        cand_lvl  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand_rank = 3'(7 - i);
            cand_lvl  = prio_base + cand_rank;
            if (isr[cand_lvl]) begin
                min_rank = cand_rank;
                min_lvl  = cand_lvl;
            end
        end
        qualify = pri_valid && (!isr_any || (req_rank < min_rank));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_q    <= 1'b1;
            lvl       <= '0;
            spurious  <= 1'b0;
            int_out   <= 1'b0;
            isr       <= '0;
            irr_clear <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            prio_base <= '0;
        end else begin
            state     <= state_nxt;
            inta_q    <= inta_n;
            lvl       <= lvl_nxt;
            spurious  <= spurious_nxt;
            int_out   <= int_out_nxt;
            isr       <= isr_nxt;
            irr_clear <= irr_clear_nxt;
            data_out  <= data_out_nxt;
            data_oe   <= data_oe_nxt;
            prio_base <= prio_base_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (qualify) state_nxt = REQ;
            REQ:     if (fall)    state_nxt = ACK1;
            ACK1:    if (rise)    state_nxt = WAIT2;
            WAIT2:   if (fall)    state_nxt = ACK2;
            ACK2:    if (rise)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        int_out_nxt   = int_out;
        irr_clear_nxt = '0;
        data_out_nxt  = data_out;
        data_oe_nxt   = data_oe;
        lvl_nxt       = lvl;
        spurious_nxt  = spurious;
        set_mask      = '0;
        aeoi_mask     = '0;
        case (state)
            IDLE: if (qualify) int_out_nxt = 1'b1;
            REQ: if (fall) begin
                int_out_nxt = 1'b0;
                if (ack_valid) begin
                    lvl_nxt       = pri_level;
                    spurious_nxt  = 1'b0;
                    set_mask      = 8'b1 << pri_level;
                    irr_clear_nxt = 8'b1 << pri_level;
                end else begin
                    lvl_nxt      = 3'd7;
                    spurious_nxt = 1'b1;
                end
            end
            WAIT2: if (fall) begin
                data_out_nxt = {vector_base, lvl};
                data_oe_nxt  = 1'b1;
            end
            ACK2: if (rise) begin
                data_oe_nxt = 1'b0;
                if (aeoi && !spurious) aeoi_mask = 8'b1 << lvl;
            end
            default: ;
        endcase

        // EOI target comes from the pre-update ISR; a same-cycle set on the same bit wins.
        eoi_tgt  = eoi_specific ? eoi_level : min_lvl;
        eoi_hit  = eoi_req && isr[eoi_tgt];
        eoi_mask = eoi_hit ? (8'b1 << eoi_tgt) : '0;
        isr_nxt  = (isr & ~eoi_mask & ~aeoi_mask) | set_mask;

        prio_base_nxt = prio_base;
        if (rotate_on_eoi) begin
            if (eoi_hit)         prio_base_nxt = eoi_tgt + 3'd1;
            else if (|aeoi_mask) prio_base_nxt = lvl + 3'd1;
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: expectations are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, imr;
    logic       pri_valid;
    logic [2:0] pri_level;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi, rotate_on_eoi, eoi_req, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out, data_oe;
    logic [7:0] isr, irr_clear, data_out;
    logic [2:0] prio_base;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr),
        .pri_valid(pri_valid), .pri_level(pri_level), .inta_n(inta_n),
        .vector_base(vector_base), .aeoi(aeoi), .rotate_on_eoi(rotate_on_eoi),
        .eoi_req(eoi_req), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .int_out(int_out), .isr(isr), .irr_clear(irr_clear),
        .data_out(data_out), .data_oe(data_oe), .prio_base(prio_base)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_req(input logic [7:0] r, input logic v, input logic [2:0] l);
        irr       = r;
        pri_valid = v;
        pri_level = l;
    endtask

    initial begin
        rst_n = 1'b0; irr = '0; imr = '0; pri_valid = 1'b0; pri_level = '0;
        inta_n = 1'b1; vector_base = 5'h10; aeoi = 1'b0; rotate_on_eoi = 1'b0;
        eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = '0;

        // Reset state
        tick(2);
        sb_push("rst_int_out", 16'h0);   check(16'(int_out));
        sb_push("rst_isr", 16'h0);       check(16'(isr));
        sb_push("rst_irr_clear", 16'h0); check(16'(irr_clear));
        sb_push("rst_data_out", 16'h0);  check(16'(data_out));
        sb_push("rst_data_oe", 16'h0);   check(16'(data_oe));
        sb_push("rst_prio_base", 16'h0); check(16'(prio_base));
        rst_n = 1'b1;
        tick();

        // Basic acknowledge, level 3
        set_req(8'h08, 1'b1, 3'd3);
        sb_push("basic_int_rise", 16'h1);
        tick(); check(16'(int_out));
        inta_n = 1'b0;
        sb_push("basic_isr_set", 16'h08);
        sb_push("basic_irr_clear", 16'h08);
        sb_push("basic_int_fall", 16'h0);
        tick(); check(16'(isr)); check(16'(irr_clear)); check(16'(int_out));
        set_req(8'h00, 1'b0, 3'd0);
        inta_n = 1'b1;
        sb_push("basic_irr_clear_once", 16'h00);
        tick(); check(16'(irr_clear));
        inta_n = 1'b0;
        sb_push("basic_vector", 16'h83);
        sb_push("basic_oe_on", 16'h1);
        tick(); check(16'(data_out)); check(16'(data_oe));
        inta_n = 1'b1;
        sb_push("basic_oe_off", 16'h0);
        sb_push("basic_isr_held", 16'h08);
        tick(); check(16'(data_oe)); check(16'(isr));

        // Nesting: level 5 blocked by level 3 in service, level 1 accepted
        set_req(8'h20, 1'b1, 3'd5);
        sb_push("nest_lower_blocked", 16'h0);
        tick(2); check(16'(int_out));
        set_req(8'h22, 1'b1, 3'd1);
        sb_push("nest_higher_int", 16'h1);
        tick(); check(16'(int_out));
        inta_n = 1'b0;
        sb_push("nest_isr", 16'h0A);
        sb_push("nest_irr_clear", 16'h02);
        tick(); check(16'(isr)); check(16'(irr_clear));
        set_req(8'h20, 1'b0, 3'd0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0;
        sb_push("nest_vector", 16'h81);
        tick(); check(16'(data_out));
        inta_n = 1'b1; tick();

        // Non-specific EOI with rotation clears level 1
        rotate_on_eoi = 1'b1; eoi_specific = 1'b0; eoi_req = 1'b1;
        sb_push("ns_eoi_isr", 16'h08);
        sb_push("ns_eoi_prio_base", 16'h2);
        tick(); check(16'(isr)); check(16'(prio_base));
        eoi_req = 1'b0;

        // Specific EOI without rotation clears level 3
        rotate_on_eoi = 1'b0; eoi_specific = 1'b1; eoi_level = 3'd3; eoi_req = 1'b1;
        sb_push("sp_eoi_isr", 16'h00);
        sb_push("sp_eoi_prio_base", 16'h2);
        tick(); check(16'(isr)); check(16'(prio_base));
        eoi_req = 1'b0; eoi_specific = 1'b0;

        // AEOI with rotation, level 3
        aeoi = 1'b1; rotate_on_eoi = 1'b1;
        set_req(8'h08, 1'b1, 3'd3);
        sb_push("aeoi_int_rise", 16'h1);
        tick(); check(16'(int_out));
        inta_n = 1'b0;
        sb_push("aeoi_isr_set", 16'h08);
        tick(); check(16'(isr));
        set_req(8'h00, 1'b0, 3'd0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0;
        sb_push("aeoi_vector", 16'h83);
        tick(); check(16'(data_out));
        inta_n = 1'b1;
        sb_push("aeoi_isr_clear", 16'h00);
        sb_push("aeoi_prio_base", 16'h4);
        tick(); check(16'(isr)); check(16'(prio_base));
        aeoi = 1'b0; rotate_on_eoi = 1'b0;

        // Spurious: request vanishes before first INTA
        vector_base = 5'h15;
        set_req(8'h10, 1'b1, 3'd4);
        tick();
        set_req(8'h00, 1'b0, 3'd0);
        sb_push("spur_int_holds", 16'h1);
        tick(); check(16'(int_out));
        inta_n = 1'b0;
        sb_push("spur_isr", 16'h00);
        sb_push("spur_irr_clear", 16'h00);
        sb_push("spur_int_fall", 16'h0);
        tick(); check(16'(isr)); check(16'(irr_clear)); check(16'(int_out));
        inta_n = 1'b1; tick();
        inta_n = 1'b0;
        sb_push("spur_vector", 16'hAF);
        tick(); check(16'(data_out));
        inta_n = 1'b1; tick();

        // Rotated priority (base 4): level 5 in service, level 2 blocked, level 4 nests
        set_req(8'h20, 1'b1, 3'd5);
        tick();
        inta_n = 1'b0; tick();
        set_req(8'h00, 1'b0, 3'd0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0;
        sb_push("rot_vector", 16'hAD);
        tick(); check(16'(data_out));
        inta_n = 1'b1; tick();
        set_req(8'h04, 1'b1, 3'd2);
        sb_push("rot_lower_blocked", 16'h0);
        tick(2); check(16'(int_out));
        set_req(8'h14, 1'b1, 3'd4);
        sb_push("rot_higher_int", 16'h1);
        tick(); check(16'(int_out));
        inta_n = 1'b0;
        sb_push("rot_isr", 16'h30);
        tick(); check(16'(isr));
        set_req(8'h04, 1'b0, 3'd0);
        inta_n = 1'b1; tick();

        // Reset while in WAIT2
        rst_n = 1'b0;
        #1;
        sb_push("mid_rst_int_out", 16'h0);   check(16'(int_out));
        sb_push("mid_rst_data_oe", 16'h0);   check(16'(data_oe));
        sb_push("mid_rst_isr", 16'h00);      check(16'(isr));
        sb_push("mid_rst_prio_base", 16'h0); check(16'(prio_base));
        tick();
        rst_n = 1'b1;
        tick();
        set_req(8'h04, 1'b1, 3'd2);
        sb_push("post_rst_idle_int", 16'h1);
        tick(); check(16'(int_out));
        set_req(8'h00, 1'b0, 3'd0);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
